// File: rtl/avalon_st_packetizer.sv
// Avalon-ST framing stage: turns an unframed FIFO word stream into
// sop/eop/empty packets whose byte length arrives on a side handshake.
module avalon_st_packetizer #(
  parameter int DATABITS_PER_SYMBOL = 8,
  parameter int SYMBOLS_PER_BEAT    = 4,
  parameter int WIDTH       = SYMBOLS_PER_BEAT*DATABITS_PER_SYMBOL,
  parameter int EMPTY_WIDTH = $clog2(SYMBOLS_PER_BEAT),
  parameter int LEN_WIDTH   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [LEN_WIDTH-1:0]   pkt_len_i,
  input  logic                   pkt_len_valid_i,
  output logic                   pkt_len_ready_o,
  input  logic [WIDTH-1:0]       snk_data_i,
  input  logic                   snk_valid_i,
  output logic                   snk_ready_o,
  output logic [WIDTH-1:0]       src_data_o,
  output logic                   src_valid_o,
  input  logic                   src_ready_i,
  output logic                   src_sop_o,
  output logic                   src_eop_o,
  output logic [EMPTY_WIDTH-1:0] src_empty_o,
  output logic [15:0]            pkt_cnt_o,
  output logic                   busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t                 state_q;
  logic [LEN_WIDTH-1:0]   beats_q;
  logic [EMPTY_WIDTH-1:0] last_empty_q;
  logic                   first_q;
  logic                   len_rdy_q;
  logic [WIDTH-1:0]       data_q;
  logic                   valid_q;
  logic                   sop_q;
  logic                   eop_q;
  logic [EMPTY_WIDTH-1:0] empty_q;
  logic [15:0]            cnt_q;

  logic [EMPTY_WIDTH-1:0] len_rem;
  logic [LEN_WIDTH-1:0]   len_beats_d;
  logic [EMPTY_WIDTH-1:0] len_empty_d;
  logic                   len_hs;
  logic                   snk_rdy;
  logic                   snk_hs;
  logic                   src_hs;
  logic                   beat_last;

  // Length decode: ceil division done as shift plus remainder flag so
  // the maximum length cannot overflow the beat counter.
  assign len_rem     = pkt_len_i[EMPTY_WIDTH-1:0];
  assign len_beats_d = (pkt_len_i >> EMPTY_WIDTH)
                     + {{(LEN_WIDTH-1){1'b0}}, |len_rem};
  assign len_empty_d = (~len_rem)
                     + {{(EMPTY_WIDTH-1){1'b0}}, 1'b1};

  // Handshakes; sink ready never depends on sink valid.
  assign len_hs    = pkt_len_valid_i && len_rdy_q;
  assign snk_rdy   = (state_q == ACTIVE) && (beats_q != '0)
                   && (!valid_q || src_ready_i);
  assign snk_hs    = snk_rdy && snk_valid_i;
  assign src_hs    = valid_q && src_ready_i;
  assign beat_last = (beats_q == {{(LEN_WIDTH-1){1'b0}}, 1'b1});

  // Packet FSM plus registered output beat.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      beats_q      <= '0;
      last_empty_q <= '0;
      first_q      <= 1'b0;
      len_rdy_q    <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      empty_q      <= '0;
      cnt_q        <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          len_rdy_q <= 1'b1;
          if (len_hs && (pkt_len_i != '0)) begin
            state_q      <= ACTIVE;
            len_rdy_q    <= 1'b0;
            beats_q      <= len_beats_d;
            last_empty_q <= len_empty_d;
            first_q      <= 1'b1;
          end
        end
        ACTIVE: begin
          if (snk_hs && beat_last) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (src_hs && eop_q) begin
            state_q   <= IDLE;
            len_rdy_q <= 1'b1;
            cnt_q     <= cnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase

      if (snk_hs) begin
        data_q  <= snk_data_i;
        valid_q <= 1'b1;
        sop_q   <= first_q;
        eop_q   <= beat_last;
        empty_q <= beat_last ? last_empty_q : '0;
        beats_q <= beats_q - {{(LEN_WIDTH-1){1'b0}}, 1'b1};
        first_q <= 1'b0;
      end else if (src_hs) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign pkt_len_ready_o = len_rdy_q;
  assign snk_ready_o     = snk_rdy;
  assign src_data_o      = data_q;
  assign src_valid_o     = valid_q;
  assign src_sop_o       = sop_q;
  assign src_eop_o       = eop_q;
  assign src_empty_o     = empty_q;
  assign pkt_cnt_o       = cnt_q;
  assign busy_o          = (state_q != IDLE);

endmodule

// File: doc/avalon_st_packetizer.md
# avalon_st_packetizer

Avalon-ST framing stage that sits directly downstream of the FIFO read port. It consumes the FIFO's unframed word stream (valid/ready, ready latency 0) and emits Avalon-ST packets with startofpacket, endofpacket and empty. Each packet's byte length comes from a separate length handshake. Output is registered, and full throughput of one beat per cycle is sustained under backpressure.

## Interface
- DATABITS_PER_SYMBOL, 8, bits per symbol
- SYMBOLS_PER_BEAT, 4, symbols per beat (power of two, ≥2)
- WIDTH, SYMBOLS_PER_BEAT*DATABITS_PER_SYMBOL, data width
- EMPTY_WIDTH, $clog2(SYMBOLS_PER_BEAT), width of empty field
- LEN_WIDTH, 16, width of packet byte length
- clk_i  in  1  single clock; all logic on rising edge
- rst_i  in  1  reset, synchronous, active-low
- pkt_len_i  in  LEN_WIDTH  packet length in bytes (symbols)
- pkt_len_valid_i  in  1  length valid
- pkt_len_ready_o  out  1  length accepted when valid&ready
- snk_data_i  in  WIDTH  word from FIFO
- snk_valid_i  in  1  FIFO not empty
- snk_ready_o  out  1  read enable to FIFO
- src_data_o  out  WIDTH  packet data
- src_valid_o  out  1  output beat valid
- src_ready_i  in  1  downstream ready (latency 0)
- src_sop_o  out  1  first beat of packet
- src_eop_o  out  1  last beat of packet
- src_empty_o  out  EMPTY_WIDTH  unused symbols in eop beat, else 0
- pkt_cnt_o  out  16  completed packets, wraps
- busy_o  out  1  state != IDLE

## Operation
- States: IDLE, ACTIVE, DRAIN.
- IDLE:
  - pkt_len_ready_o=1.
  - On handshake with pkt_len_i≠0: latch beats = ceil(len/SYMBOLS_PER_BEAT) and last_empty = (SYMBOLS_PER_BEAT − len mod SYMBOLS_PER_BEAT) mod SYMBOLS_PER_BEAT, then go to ACTIVE.
  - pkt_len_i=0 is consumed and discarded: stay IDLE, no output, pkt_cnt_o unchanged.
- ACTIVE:
  - snk_ready_o = (beats_left>0) && (!src_valid_o || src_ready_i).
  - Each snk handshake loads the output register with data; sop = first beat of packet; eop = (beats_left==1); empty = eop ? last_empty : 0; beats_left decrements.
  - Last beat accepted → DRAIN.
- DRAIN:
  - snk_ready_o=0.
  - When src_valid_o && src_eop_o && src_ready_i: pkt_cnt_o += 1 (mod 2^16) and go to IDLE.
- Output register: src_valid_o clears on a src handshake with no new sink beat in the same cycle. While src_valid_o && !src_ready_i, all src_* outputs hold stable.
- pkt_len_ready_o is 0 outside IDLE. Lengths offered early wait.
- Beat counter width is LEN_WIDTH. Max length 2^LEN_WIDTH−1 gives ceil((2^LEN_WIDTH−1)/SYMBOLS_PER_BEAT) beats with no overflow.
- Sink words beyond the current packet are never consumed until the next length is accepted.

## Timing
- Reset (rst_i=0 at a clock edge) gives on the next cycle:
  - state IDLE
  - src_valid_o, src_sop_o, src_eop_o, src_data_o, src_empty_o, snk_ready_o, pkt_cnt_o, busy_o = 0
  - pkt_len_ready_o = 0
- pkt_len_ready_o is registered. It goes 1 on the first cycle after rst_i returns high.
- Reset mid-packet: the partial packet is abandoned and src_valid_o drops next cycle with no eop. Unconsumed FIFO words stay in the FIFO.
- Length handshake at cycle t → ACTIVE at t+1; snk_ready_o can be 1 at t+1.
- Sink handshake at cycle t → beat on src_* at t+1 (1-cycle latency).
- With src_ready_i=1 and snk_valid_i=1 continuously: one beat per cycle, no bubbles within a packet.
- eop handshake at t → IDLE at t+1, pkt_len_ready_o=1 at t+1. Minimum one idle cycle between packets.
- Simultaneous src handshake and snk handshake in the same cycle: the register reloads; src_valid_o stays 1.
- snk_ready_o is a combinational function of state, beats_left, src_valid_o and src_ready_i. No combinational path exists from snk_valid_i to snk_ready_o.

## Test plan
- Length 16, SYMBOLS_PER_BEAT=4, words 0x0..0x3, src_ready_i=1 → 4 beats on consecutive cycles; sop on beat 0, eop on beat 3, empty=0; pkt_cnt_o=1.
- Length 6 → 2 beats; eop beat has empty=2. Length 1 → 1 beat with sop=eop=1, empty=3.
- Length 12, src_ready_i toggled 1/0 each cycle → 3 beats delivered in order; data/sop/eop/empty stable while stalled; no FIFO word lost or duplicated.
- snk_valid_i gaps (FIFO empty for 3 cycles mid-packet) → src_valid_o gaps; beat order and eop on beat 3 preserved.
- Length 0, then length 4 → first produces no output and no count change; second gives 1 beat, pkt_cnt_o=1.
- Reset asserted after 2 of 4 beats → next cycle all outputs 0; after release, length 8 gives a fresh packet with sop on its first beat.
